// File: rtl/i2s_pkg.sv
// Shared types for the I2S receiver: default sample width, the signed
// sample type handed downstream, and the receiver FSM state encoding.
package i2s_pkg;

  localparam int DATA_W_DEF = 24;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    PAD   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// sync_edge: multi-stage synchroniser for an asynchronous clock-like input
// plus a bundle of data inputs that travel through the same number of
// stages, so their relative alignment is kept. Emits a one-clk pulse on
// each rising edge of the synchronised clock-like input.
// STAGES must be at least 2.
module sync_edge #(
  parameter int STAGES = 2,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              edge_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              edge_rise_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int W = DATA_W + 1;

  // stage_q[0] is the first (metastable-prone) flop; stage_q[STAGES-1] is safe
  logic [STAGES-1:0][W-1:0] stage_q;
  logic                     edge_prev_q;

  // Shift the edge signal and data bundle together through the chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], {edge_i, data_i}};
    end
  end

  // Remember the last synchronised level of the edge signal
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_prev_q <= 1'b0;
    end else begin
      edge_prev_q <= stage_q[STAGES-1][W-1];
    end
  end

  assign edge_rise_o = stage_q[STAGES-1][W-1] & ~edge_prev_q;
  assign data_o      = stage_q[STAGES-1][DATA_W-1:0];

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: oversampling I2S receiver. Deserialises MSB-first two's complement
// words from an asynchronous I2S stream and presents each left/right pair
// with a one-clk sample_valid strobe; malformed slots give a frame_err pulse.
// Optional build macro I2S_RX_LJ_EN selects left-justified framing (no
// one-bit delay after the word-select edge).
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SLOT_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i2s_bclk,
  input  logic                     i2s_lrclk,
  input  logic                     i2s_sdata,
  output logic signed [DATA_W-1:0] sample_l,
  output logic signed [DATA_W-1:0] sample_r,
  output logic                     sample_valid,
  output logic                     frame_err
);

`ifdef I2S_RX_LJ_EN
  localparam bit LJ_MODE = 1'b1;
`else
  localparam bit LJ_MODE = 1'b0;
`endif

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PAD_W = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [PAD_W-1:0] PAD_MAX  = PAD_W'(SLOT_W);

  // Synchronised inputs
  logic       bclk_rise;
  logic [1:0] lr_sd_s;
  logic       lrclk_s;
  logic       sdata_s;

  sync_edge #(
    .STAGES (SYNC_STAGES),
    .DATA_W (2)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .edge_i      (i2s_bclk),
    .data_i      ({i2s_lrclk, i2s_sdata}),
    .edge_rise_o (bclk_rise),
    .data_o      (lr_sd_s)
  );

  assign lrclk_s = lr_sd_s[1];
  assign sdata_s = lr_sd_s[0];

  // Receiver state
  rx_state_t         state_q,    state_d;
  logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [PAD_W-1:0]  pad_cnt_q,  pad_cnt_d;
  logic [DATA_W-1:0] shreg_q,    shreg_d;
  logic              chan_q,     chan_d;
  logic              lr_prev_q,  lr_prev_d;
  logic [DATA_W-1:0] hold_l_q,   hold_l_d;
  logic              hold_vld_q, hold_vld_d;
  logic              emit_q,     emit_d;
  logic              err_q,      err_d;

  // Output registers
  logic [DATA_W-1:0] sample_l_q;
  logic [DATA_W-1:0] sample_r_q;
  logic              sample_valid_q;

  logic [DATA_W-1:0] shifted;
  logic              word_edge;
  logic              start_slot;

  assign shifted   = {shreg_q[DATA_W-2:0], sdata_s};
  assign word_edge = (lrclk_s != lr_prev_q);

  // Slot framing FSM; everything advances only on a synchronised BCLK rise
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    pad_cnt_d  = pad_cnt_q;
    shreg_d    = shreg_q;
    chan_d     = chan_q;
    lr_prev_d  = lr_prev_q;
    hold_l_d   = hold_l_q;
    hold_vld_d = hold_vld_q;
    emit_d     = 1'b0;
    err_d      = 1'b0;
    start_slot = 1'b0;

    if (bclk_rise) begin
      lr_prev_d = lrclk_s;

      case (state_q)
        ALIGN: begin
          // Lock only on the right-to-left transition so a frame starts at L
          if (word_edge && !lrclk_s) begin
            start_slot = 1'b1;
          end
        end

        DELAY, SHIFT: begin
          if (word_edge) begin
            // Slot ended before the word was complete (edge wins over LSB)
            err_d      = 1'b1;
            start_slot = 1'b1;
          end else begin
            // The edge rise was the delay bit, so DELAY captures the MSB here
            shreg_d   = shifted;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            state_d   = SHIFT;
            if (state_q == SHIFT && bit_cnt_q == BIT_LAST) begin
              state_d   = PAD;
              pad_cnt_d = '0;
              if (!chan_q) begin
                hold_l_d   = shifted;
                hold_vld_d = 1'b1;
              end else begin
                emit_d     = hold_vld_q;
                hold_vld_d = 1'b0;
              end
            end
          end
        end

        PAD: begin
          if (word_edge) begin
            start_slot = 1'b1;
          end else if (pad_cnt_q == PAD_MAX) begin
            // Too many bits without a word edge: lost framing, re-align
            err_d      = 1'b1;
            state_d    = ALIGN;
            hold_vld_d = 1'b0;
          end else begin
            pad_cnt_d = pad_cnt_q + PAD_W'(1);
          end
        end

        default: state_d = ALIGN;
      endcase

      if (start_slot) begin
        chan_d    = lrclk_s;
        bit_cnt_d = '0;
        // A held left word is only valid for the right slot that follows it
        if (err_d || !lrclk_s) begin
          hold_vld_d = 1'b0;
        end
        if (LJ_MODE) begin
          shreg_d   = shifted;
          bit_cnt_d = CNT_W'(1);
          state_d   = SHIFT;
        end else begin
          state_d = DELAY;
        end
      end
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ALIGN;
      bit_cnt_q  <= '0;
      pad_cnt_q  <= '0;
      shreg_q    <= '0;
      chan_q     <= 1'b0;
      lr_prev_q  <= 1'b0;
      hold_l_q   <= '0;
      hold_vld_q <= 1'b0;
      emit_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      pad_cnt_q  <= pad_cnt_d;
      shreg_q    <= shreg_d;
      chan_q     <= chan_d;
      lr_prev_q  <= lr_prev_d;
      hold_l_q   <= hold_l_d;
      hold_vld_q <= hold_vld_d;
      emit_q     <= emit_d;
      err_q      <= err_d;
    end
  end

  // Publish a completed pair one clk after the right LSB was captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_l_q     <= '0;
      sample_r_q     <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= emit_q;
      if (emit_q) begin
        sample_l_q <= hold_l_q;
        sample_r_q <= shreg_q;
      end
    end
  end

  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
  assign sample_valid = sample_valid_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: drives an I2S stream (BCLK = clk/8),
// queues the expected L/R pairs per frame, and a monitor pops and compares
// on every sample_valid, also checking latency and frame spacing.
module tb_i2s_rx;
  import i2s_pkg::*;

  localparam int DW   = 24;
  localparam int SLOT = 32;
  localparam int SS   = 2;
  localparam int HALF = 40;  // BCLK half period in time units (clk period 10)
`ifdef I2S_RX_LJ_EN
  localparam int OFF = 0;
`else
  localparam int OFF = 1;
`endif

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    bit            gap;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          bclk  = 1'b0;
  logic          lrclk = 1'b1;
  logic          sdata = 1'b0;
  logic [DW-1:0] sample_l;
  logic [DW-1:0] sample_r;
  logic          sample_valid;
  logic          frame_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lsb_cyc = 0;
  int   err_exp = 0;
  int   err_seen = 0;
  bit   prev_clean = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  i2s_rx #(
    .DATA_W      (DW),
    .SLOT_W      (SLOT),
    .SYNC_STAGES (SS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i2s_bclk     (bclk),
    .i2s_lrclk    (lrclk),
    .i2s_sdata    (sdata),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One BCLK period: lrclk/sdata change with the falling edge
  task automatic drive_bit(input logic lr, input logic sd, input bit is_lsb, input bit do_rst);
    bclk  = 1'b0;
    lrclk = lr;
    sdata = sd;
    if (do_rst) begin
      #10;
      rst = 1'b1;
      #1;
      chk("rst_sample_l", 48'(sample_l), 48'h0);
      chk("rst_sample_r", 48'(sample_r), 48'h0);
      chk("rst_valid", 48'(sample_valid), 48'h0);
      chk("rst_frame_err", 48'(frame_err), 48'h0);
      #29;
    end else begin
      #HALF;
    end
    bclk = 1'b1;
    if (is_lsb) lsb_cyc = cyc;
    if (do_rst) begin
      #30;
      rst = 1'b0;
      #10;
    end else begin
      #HALF;
    end
  endtask

  // Send slot bit positions k0..k1-1 (position 0 carries the word-select edge)
  task automatic send_slot(input logic lr, input logic [DW-1:0] w,
                           input int k0, input int k1, input int rst_k);
    for (int k = k0; k < k1; k++) begin
      int   bi;
      logic sd;
      bi = k - OFF;
      if (bi >= 0 && bi < DW) sd = w[DW-1-bi];
      else                    sd = 1'($urandom_range(0, 1));
      drive_bit(lr, sd, (lr == 1'b1) && (bi == DW - 1), k == rst_k);
    end
  endtask

  // A complete L/R frame the receiver must deliver
  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    exp_q.push_back(exp_t'{l, r, prev_clean});
    prev_clean = 1'b1;
    send_slot(1'b0, l, 0, SLOT, -1);
    send_slot(1'b1, r, 0, SLOT, -1);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    bit   prev_valid;
    int   last_valid_cyc;
    prev_valid     = 1'b0;
    last_valid_cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (frame_err === 1'b1) err_seen++;
      if (sample_valid === 1'b1) begin
        chk("valid_single_pulse", 48'(prev_valid), 48'h0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got L=%h R=%h expected no pulse", sample_l, sample_r);
        end else begin
          e = exp_q.pop_front();
          chk("sample_l", 48'(sample_l), 48'(e.l));
          chk("sample_r", 48'(sample_r), 48'(e.r));
          chk("latency", 48'(cyc - lsb_cyc), 48'(SS + 2));
          if (e.gap) chk("frame_spacing", 48'(cyc - last_valid_cyc), 48'(2 * SLOT * 8));
        end
        last_valid_cyc = cyc;
      end
      prev_valid = (sample_valid === 1'b1);
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $display("Simulation finished: %0d checks, %0d errors", checks + 1, errors + 1);
    $fatal(1);
  end

  // Stimulus
  initial begin
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    #23;
    chk("reset_sample_l", 48'(sample_l), 48'h0);
    chk("reset_sample_r", 48'(sample_r), 48'h0);
    chk("reset_valid", 48'(sample_valid), 48'h0);
    chk("reset_frame_err", 48'(frame_err), 48'h0);
    rst = 1'b0;
    #20;

    // Stream starts halfway through a right slot: that frame is lost
    send_slot(1'b1, DW'($urandom), SLOT / 2, SLOT, -1);
    prev_clean = 1'b0;
    send_frame(24'h123456, 24'hFEDCBA);

    // Back-to-back frames including full-scale extremes
    send_frame(24'h000001, 24'hFFFFFF);
    send_frame(24'h7FFFFF, 24'h800000);
    send_frame(24'h000000, 24'h000005);
    chk("err_after_clean", 48'(err_seen), 48'(err_exp));

    // Short left slot: word select toggles after 16 data bits
    send_slot(1'b0, DW'($urandom), 0, OFF + 16, -1);
    err_exp++;
    send_slot(1'b1, DW'($urandom), 0, SLOT, -1);
    chk("err_short_slot", 48'(err_seen), 48'(err_exp));
    prev_clean = 1'b0;
    send_frame(DW'($urandom), DW'($urandom));

    // Overrun: left slot far longer than SLOT_W
    send_slot(1'b0, DW'($urandom), 0, 2 * SLOT + 1, -1);
    err_exp++;
    send_slot(1'b1, DW'($urandom), 0, SLOT, -1);
    chk("err_overrun", 48'(err_seen), 48'(err_exp));
    prev_clean = 1'b0;
    send_frame(DW'($urandom), DW'($urandom));

    // Reset during bit 10 of a right word
    send_frame(24'hA5A5A5, 24'h5A5A5A);
    send_slot(1'b0, DW'($urandom), 0, SLOT, -1);
    send_slot(1'b1, DW'($urandom), 0, SLOT, OFF + 10);
    prev_clean = 1'b0;
    send_frame(DW'($urandom), DW'($urandom));
    chk("err_after_reset", 48'(err_seen), 48'(err_exp));

    // Random frames
    for (int i = 0; i < 8; i++) begin
      a = DW'($urandom);
      b = DW'($urandom);
      send_frame(a, b);
    end

    // 64-point sine, amplitude 120, on both channels
    for (int i = 0; i < 64; i++) begin
      real s;
      int  v;
      s = 120.0 * $sin(2.0 * 3.141592653589793 * real'(i) / 64.0);
      v = (s >= 0.0) ? $rtoi(s + 0.5) : $rtoi(s - 0.5);
      a = v[DW-1:0];
      send_frame(a, a);
    end

    repeat (20) @(posedge clk);
    chk("pending_expected", 48'(exp_q.size()), 48'h0);
    chk("err_final", 48'(err_seen), 48'(err_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
